// File: rtl/lattice_reader.sv
// Raster-order reader for the nine distribution BRAMs: issues one shared read address per
// cell and streams density/barrier results through a credit-controlled skid FIFO. Optional VELOCITY_EN adds ux_out.
module lattice_reader #(
  parameter int HPIXELS    = 320,
  parameter int VPIXELS    = 180,
  parameter int RW_LATENCY = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS),
  localparam int HW        = (HPIXELS > 1) ? $clog2(HPIXELS) : 1,
  localparam int VW        = (VPIXELS > 1) ? $clog2(VPIXELS) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  output logic [8:0][BRAM_SIZE-1:0]   addr_out,
  input  logic [8:0][7:0]             data_in,
  output logic                        pix_valid_out,
  input  logic                        pix_ready_in,
  output logic [HW-1:0]               pix_hor_out,
  output logic [VW-1:0]               pix_vert_out,
  output logic [11:0]                 density_out,
  output logic                        barrier_out,
`ifdef VELOCITY_EN
  output logic signed [10:0]          ux_out,
`endif
  output logic                        busy_out,
  output logic                        done_out,
  output logic [1:0]                  state_out
);

  // Handshake: a result transfers on every rising clk_in where pix_valid_out && pix_ready_in;
  // while pix_valid_out is high and pix_ready_in low the pix_* outputs do not change.

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HPIXELS - 1);
  localparam logic [VW-1:0] VMAX = VW'(VPIXELS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [HW-1:0]        hor;
  logic [VW-1:0]        vert;
  logic [BRAM_SIZE-1:0] cell_idx;
  logic [BRAM_SIZE-1:0] addr_q;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          credit_used;
  logic                 credit_ok;
  logic                 last_cell;
  logic                 issue;
  logic                 push;
  logic                 pop;

  logic [RW_LATENCY:0]  pipe_valid;
  logic [HW-1:0]        pipe_hor  [RW_LATENCY+1];
  logic [VW-1:0]        pipe_vert [RW_LATENCY+1];

  logic [11:0]          density_c;
  logic                 barrier_c;

  logic [HW-1:0]        fifo_hor  [FIFO_DEPTH];
  logic [VW-1:0]        fifo_vert [FIFO_DEPTH];
  logic [11:0]          fifo_dens [FIFO_DEPTH];
  logic                 fifo_bar  [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both reads still in the BRAM pipe and results already buffered.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
  assign last_cell   = (hor == HMAX) && (vert == VMAX);
  assign push        = pipe_valid[RW_LATENCY];
  assign pop         = pix_valid_out && pix_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start_in) state_nxt = ISSUE;
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (last_cell) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) &&
            ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop)))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_out  = (state == ISSUE) || (state == DRAIN);
  assign done_out  = (state == DONE);
  assign state_out = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hor      <= '0;
      vert     <= '0;
      cell_idx <= '0;
      addr_q   <= '0;
      inflight <= '0;
    end else begin
      if ((state == IDLE) && start_in) begin
        hor      <= '0;
        vert     <= '0;
        cell_idx <= '0;
      end else if (issue) begin
        addr_q   <= cell_idx;
        cell_idx <= cell_idx + BRAM_SIZE'(1);
        if (hor == HMAX) begin
          hor  <= '0;
          vert <= (vert == VMAX) ? '0 : vert + VW'(1);
        end else begin
          hor  <= hor + HW'(1);
        end
      end
      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

  assign addr_out = {9{addr_q}};

  // Stage 0 loads with the address; the tag reaches the last stage in the cycle its data arrives.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe_valid <= '0;
      for (int i = 0; i <= RW_LATENCY; i++) begin
        pipe_hor[i]  <= '0;
        pipe_vert[i] <= '0;
      end
    end else begin
      pipe_valid   <= {pipe_valid[RW_LATENCY-1:0], issue};
      pipe_hor[0]  <= hor;
      pipe_vert[0] <= vert;
      for (int i = 1; i <= RW_LATENCY; i++) begin
        pipe_hor[i]  <= pipe_hor[i-1];
        pipe_vert[i] <= pipe_vert[i-1];
      end
    end
  end

  always_comb begin
    density_c = '0;
    for (int i = 0; i < 9; i++) density_c = density_c + 12'(data_in[i]);
    barrier_c = (data_in[0] == 8'hFF) && (data_in[8:1] == '0);
  end

`ifdef VELOCITY_EN
  logic [9:0]         ux_pos, ux_neg;
  logic signed [10:0] ux_c;
  logic signed [10:0] fifo_ux [FIFO_DEPTH];

  always_comb begin
    ux_pos = 10'(data_in[1]) + 10'(data_in[5]) + 10'(data_in[8]);
    ux_neg = 10'(data_in[3]) + 10'(data_in[6]) + 10'(data_in[7]);
    ux_c   = barrier_c ? '0 : $signed({1'b0, ux_pos}) - $signed({1'b0, ux_neg});
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_ux[i] <= '0;
    end else if (push) begin
      fifo_ux[wr_ptr] <= ux_c;
    end
  end

  assign ux_out = fifo_ux[rd_ptr];
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_hor[i]  <= '0;
        fifo_vert[i] <= '0;
        fifo_dens[i] <= '0;
        fifo_bar[i]  <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_hor[wr_ptr]  <= pipe_hor[RW_LATENCY];
        fifo_vert[wr_ptr] <= pipe_vert[RW_LATENCY];
        fifo_dens[wr_ptr] <= density_c;
        fifo_bar[wr_ptr]  <= barrier_c;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign pix_valid_out = (fifo_count != '0);
  assign pix_hor_out   = fifo_hor[rd_ptr];
  assign pix_vert_out  = fifo_vert[rd_ptr];
  assign density_out   = fifo_dens[rd_ptr];
  assign barrier_out   = fifo_bar[rd_ptr];

endmodule

// File: tb/tb_lattice_reader.sv
// Directed bench for lattice_reader on a 4x2 lattice with a 3-cycle BRAM model.
module tb_lattice_reader;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int NCELL = H * V;
  localparam int AW    = 3;
  localparam int HW    = 2;
  localparam int VW    = 1;
`ifdef VELOCITY_EN
  localparam int RESW  = HW + VW + 12 + 1 + 11;
`else
  localparam int RESW  = HW + VW + 12 + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                 start_in = 1'b0;
  logic                 pix_ready_in = 1'b0;
  logic [8:0][AW-1:0]   addr_out;
  logic [8:0][7:0]      data_in;
  logic                 pix_valid_out;
  logic [HW-1:0]        pix_hor_out;
  logic [VW-1:0]        pix_vert_out;
  logic [11:0]          density_out;
  logic                 barrier_out;
  logic                 busy_out;
  logic                 done_out;
  logic [1:0]           state_out;
  logic [RESW-1:0]      got_vec;
`ifdef VELOCITY_EN
  logic signed [10:0]   ux_out;
  assign got_vec = {pix_hor_out, pix_vert_out, density_out, barrier_out, ux_out};
`else
  assign got_vec = {pix_hor_out, pix_vert_out, density_out, barrier_out};
`endif

  lattice_reader #(.HPIXELS(H), .VPIXELS(V), .RW_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .addr_out(addr_out), .data_in(data_in),
    .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
    .pix_hor_out(pix_hor_out), .pix_vert_out(pix_vert_out),
    .density_out(density_out), .barrier_out(barrier_out),
`ifdef VELOCITY_EN
    .ux_out(ux_out),
`endif
    .busy_out(busy_out), .done_out(done_out), .state_out(state_out)
  );

  // BRAM model: data follows the address three clock edges later.
  logic [8:0][7:0] mem [NCELL];
  logic [AW-1:0]   a1, a2, a3;
  always @(posedge clk_in) begin
    a1 <= addr_out[0];
    a2 <= a1;
    a3 <= a2;
  end
  assign data_in = mem[a3];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RESW-1:0] exp_q[$];
  int pops = 0;
  int dones = 0;
  int exp_next = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RESW-1:0] exp_res(input int p, input int c);
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [11:0]   dens;
    logic          bar;
    logic [10:0]   ux;
    h = HW'(c % H);
    v = VW'(c / H);
    dens = 12'd39;
    bar  = 1'b0;
    ux   = 11'h7F4;
    if (p == 1 && c == 6) begin
      dens = 12'd255;
      bar  = 1'b1;
      ux   = 11'd0;
    end
    if (p == 2) begin
      dens = 12'd2295;
      ux   = 11'd0;
    end
`ifdef VELOCITY_EN
    return {h, v, dens, bar, ux};
`else
    if (ux == 11'd1) dens = 12'd0;
    return {h, v, dens, bar};
`endif
  endfunction

  // ---------------- monitor ----------------
  logic            prev_stall = 1'b0;
  logic [RESW:0]   prev_vec;
  logic [RESW:0]   cur_vec;
  logic [AW-1:0]   last_addr = '0;
  logic [RESW-1:0] exp_v;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_stall = 1'b0;
      last_addr  = addr_out[0];
    end else begin
      cur_vec = {pix_valid_out, got_vec};
      if (prev_stall) check("stall_hold", 64'(cur_vec), 64'(prev_vec));
      prev_stall = pix_valid_out && !pix_ready_in;
      prev_vec   = cur_vec;
      if (busy_out && ((addr_out[0] != last_addr) || (exp_next == 0 && addr_out[0] == '0))) begin
        check("addr_seq", 64'(addr_out[0]), 64'(exp_next));
        check("addr_lanes", 64'(addr_out), 64'({9{addr_out[0]}}));
        exp_next++;
      end
      last_addr = addr_out[0];
      check("credit_bound", 64'((exp_next - pops) <= DEPTH), 64'd1);
      if (pix_valid_out && pix_ready_in) begin
        check("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("result", 64'(got_vec), 64'(exp_v));
        end
        pops++;
      end
      if (done_out) dones++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_pattern(input int p);
    for (int c = 0; c < NCELL; c++) begin
      for (int d = 0; d < 9; d++) mem[c][d] = (p == 2) ? 8'hFF : 8'd3;
      if (p != 2) mem[c][3] = 8'd15;
    end
    if (p == 1) begin
      mem[6] = '0;
      mem[6][0] = 8'hFF;
    end
  endtask

  task automatic fill_expect(input int p);
    exp_q.delete();
    for (int c = 0; c < NCELL; c++) exp_q.push_back(exp_res(p, c));
    pops = 0;
    dones = 0;
    exp_next = 0;
  endtask

  task automatic run_sweep(input int p, input int mode, input bit restart);
    int tail;
    load_pattern(p);
    fill_expect(p);
    @(posedge clk_in); #1;
    start_in = 1'b1;
    pix_ready_in = (mode == 0);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    tail = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (mode == 1) pix_ready_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      start_in = restart && (cyc == 6);
      @(posedge clk_in); #1;
      if (dones > 0) tail++;
      if (tail == 6) break;
    end
    start_in = 1'b0;
    pix_ready_in = 1'b1;
    check("pop_count", 64'(pops), 64'd8);
    check("done_count", 64'(dones), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("addr_count", 64'(exp_next), 64'd8);
    check("busy_after", 64'(busy_out), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    load_pattern(0);
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid", 64'(pix_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_addr", 64'(addr_out), 64'd0);
    check("rst_density", 64'(density_out), 64'd0);
    check("rst_barrier", 64'(barrier_out), 64'd0);
    check("rst_hor", 64'(pix_hor_out), 64'd0);
    check("rst_vert", 64'(pix_vert_out), 64'd0);
    check("rst_state", 64'(state_out), 64'd0);
`ifdef VELOCITY_EN
    check("rst_ux", 64'(ux_out), 64'd0);
`endif
    rst_n_in = 1'b1;

    run_sweep(0, 0, 1'b0);
    run_sweep(1, 0, 1'b0);
    run_sweep(2, 0, 1'b0);
    run_sweep(0, 1, 1'b1);

    // Abort a sweep after three results have been taken.
    load_pattern(0);
    fill_expect(0);
    @(posedge clk_in); #1;
    start_in = 1'b1;
    pix_ready_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (pops >= 3) break;
      @(posedge clk_in); #1;
    end
    check("pops_before_reset", 64'(pops), 64'd3);
    rst_n_in = 1'b0;
    exp_q.delete();
    #1;
    check("abort_valid", 64'(pix_valid_out), 64'd0);
    check("abort_busy", 64'(busy_out), 64'd0);
    check("abort_addr", 64'(addr_out), 64'd0);
    check("abort_state", 64'(state_out), 64'd0);
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_no_result", 64'(pops), 64'd3);
    run_sweep(0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
